// File: rtl/trigout_pkg.sv
// Purpose: shared types and constants for the trigger-output sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Contents: sequencer state enum, default counter widths, mux source selects.
package trigout_pkg;

  // Sequencer states; Busy is simply (state != IDLE).
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    RUN       = 2'd2,
    HOLDOFF   = 2'd3
  } state_t;

  localparam int CNT_W_DEF  = 16;
  localparam int HOLD_W_DEF = 16;

  // Trigger-out mux source selects.
  localparam logic SRC_SYNC   = 1'b0;  // Din1 sync
  localparam logic SRC_MARKER = 1'b1;  // Din2 marker

endpackage

// File: rtl/trig_edge_detect.sv
// Purpose: rising-edge detector on an already-synchronised trigger level.
// Latency: Rise is combinational from Trig against a one-cycle history register.
// Backpressure: none; samples every cycle.
// Ports: Clock, Reset (async, active-high), Trig (level in), Rise (edge out).
module trig_edge_detect (
  input  logic Clock,
  input  logic Reset,
  input  logic Trig,
  output logic Rise
);

  logic trig_q;

  // History tracks the level every cycle regardless of sequencer state, so a
  // level that was already high before arming never looks like an edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      trig_q <= 1'b0;
    end else begin
      trig_q <= Trig;
    end
  end

  assign Rise = Trig & ~trig_q;

endmodule

// File: rtl/trigout_seq_ctrl.sv
// Purpose: sequences trigger-out mux enable/select for infinite, burst and triggered runs.
// Latency: outputs registered from next-state; Mux_EN rises on the edge that samples Start.
// Backpressure: none; Start while Busy and config changes while Busy are ignored.
// Ports: Clock, Reset; run control Start/Stop; config Infinite, Ext_Trig_En,
//        Retrigger, Src_Sel, Burst_Len, Holdoff_Len (latched at Start);
//        Ext_Trig, Period_End strobes; outputs Mux_EN, Mux_Sel, Busy, Done, Period_Cnt.
module trigout_seq_ctrl
  import trigout_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int HOLD_W = HOLD_W_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Stop,
  input  logic              Infinite,
  input  logic              Ext_Trig_En,
  input  logic              Retrigger,
  input  logic              Ext_Trig,
  input  logic              Src_Sel,
  input  logic [CNT_W-1:0]  Burst_Len,
  input  logic [HOLD_W-1:0] Holdoff_Len,
  input  logic              Period_End,
  output logic              Mux_EN,
  output logic              Mux_Sel,
  output logic              Busy,
  output logic              Done,
  output logic [CNT_W-1:0]  Period_Cnt
);

  state_t state, state_nxt;

  // Latched run configuration.
  logic              infinite_q, infinite_nxt;
  logic              ext_en_q, ext_en_nxt;
  logic              retrig_q, retrig_nxt;
  logic              src_sel_q, src_sel_nxt;
  logic [CNT_W-1:0]  burst_len_q, burst_len_nxt;
  logic [HOLD_W-1:0] holdoff_len_q, holdoff_len_nxt;

  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
  logic [CNT_W-1:0]  period_cnt_nxt;
  logic              done_nxt;
  logic              trig_rise;

  trig_edge_detect u_edge (
    .Clock (Clock),
    .Reset (Reset),
    .Trig  (Ext_Trig),
    .Rise  (trig_rise)
  );

  always_comb begin
    state_nxt       = state;
    infinite_nxt    = infinite_q;
    ext_en_nxt      = ext_en_q;
    retrig_nxt      = retrig_q;
    src_sel_nxt     = src_sel_q;
    burst_len_nxt   = burst_len_q;
    holdoff_len_nxt = holdoff_len_q;
    hold_cnt_nxt    = hold_cnt;
    period_cnt_nxt  = Period_Cnt;
    done_nxt        = 1'b0;

    case (state)
      IDLE: begin
        // Stop in the same cycle cancels the Start entirely.
        if (Start && !Stop) begin
          infinite_nxt    = Infinite;
          ext_en_nxt      = Ext_Trig_En;
          retrig_nxt      = Retrigger;
          src_sel_nxt     = Src_Sel;
          burst_len_nxt   = Burst_Len;
          holdoff_len_nxt = Holdoff_Len;
          period_cnt_nxt  = '0;
          if (!Infinite && (Burst_Len == '0)) begin
            // Empty burst completes immediately without ever enabling the mux.
            done_nxt = 1'b1;
          end else if (Ext_Trig_En) begin
            state_nxt = WAIT_TRIG;
          end else begin
            state_nxt = RUN;
          end
        end
      end

      WAIT_TRIG: begin
        if (Stop) begin
          state_nxt = IDLE;
        end else if (trig_rise) begin
          state_nxt = RUN;
        end
      end

      RUN: begin
        // Stop beats a coinciding final Period_End: no Done, count untouched.
        if (Stop) begin
          state_nxt = IDLE;
        end else if (Period_End) begin
          period_cnt_nxt = Period_Cnt + CNT_W'(1);
          if (!infinite_q && (Period_Cnt == burst_len_q - CNT_W'(1))) begin
            done_nxt = 1'b1;
            if (retrig_q && ext_en_q) begin
              state_nxt    = HOLDOFF;
              hold_cnt_nxt = holdoff_len_q;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end

      HOLDOFF: begin
        // The edge that takes the counter to zero also leaves HOLDOFF, so a
        // holdoff of N spends N cycles here (0 and 1 both spend one).
        if (Stop) begin
          state_nxt = IDLE;
        end else if (hold_cnt <= HOLD_W'(1)) begin
          state_nxt      = WAIT_TRIG;
          hold_cnt_nxt   = '0;
          period_cnt_nxt = '0;
        end else begin
          hold_cnt_nxt = hold_cnt - HOLD_W'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state         <= IDLE;
      infinite_q    <= 1'b0;
      ext_en_q      <= 1'b0;
      retrig_q      <= 1'b0;
      src_sel_q     <= 1'b0;
      burst_len_q   <= '0;
      holdoff_len_q <= '0;
      hold_cnt      <= '0;
      Period_Cnt    <= '0;
      Mux_EN        <= 1'b0;
      Mux_Sel       <= 1'b0;
      Busy          <= 1'b0;
      Done          <= 1'b0;
    end else begin
      state         <= state_nxt;
      infinite_q    <= infinite_nxt;
      ext_en_q      <= ext_en_nxt;
      retrig_q      <= retrig_nxt;
      src_sel_q     <= src_sel_nxt;
      burst_len_q   <= burst_len_nxt;
      holdoff_len_q <= holdoff_len_nxt;
      hold_cnt      <= hold_cnt_nxt;
      Period_Cnt    <= period_cnt_nxt;
      Mux_EN        <= (state_nxt == RUN);
      Mux_Sel       <= (state_nxt == RUN) ? src_sel_nxt : SRC_SYNC;
      Busy          <= (state_nxt != IDLE);
      Done          <= done_nxt;
    end
  end

endmodule

// File: tb/tb_trigout_seq_ctrl.sv
module tb_trigout_seq_ctrl;

  localparam int CW = 4;
  localparam int HW = 8;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          Start = 1'b0;
  logic          Stop = 1'b0;
  logic          Infinite = 1'b0;
  logic          Ext_Trig_En = 1'b0;
  logic          Retrigger = 1'b0;
  logic          Ext_Trig = 1'b0;
  logic          Src_Sel = 1'b0;
  logic [CW-1:0] Burst_Len = '0;
  logic [HW-1:0] Holdoff_Len = '0;
  logic          Period_End = 1'b0;
  logic          Mux_EN;
  logic          Mux_Sel;
  logic          Busy;
  logic          Done;
  logic [CW-1:0] Period_Cnt;

  trigout_seq_ctrl #(.CNT_W(CW), .HOLD_W(HW)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Start       (Start),
    .Stop        (Stop),
    .Infinite    (Infinite),
    .Ext_Trig_En (Ext_Trig_En),
    .Retrigger   (Retrigger),
    .Ext_Trig    (Ext_Trig),
    .Src_Sel     (Src_Sel),
    .Burst_Len   (Burst_Len),
    .Holdoff_Len (Holdoff_Len),
    .Period_End  (Period_End),
    .Mux_EN      (Mux_EN),
    .Mux_Sel     (Mux_Sel),
    .Busy        (Busy),
    .Done        (Done),
    .Period_Cnt  (Period_Cnt)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic          st, sp, inf, ee, tr, src, pe;
    logic [CW-1:0] bl;
    logic          en, sel, busy, done;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t v(input logic st, sp, inf, ee, tr, src, pe,
                             input logic [CW-1:0] bl,
                             input logic en, sel, busy, done,
                             input logic [CW-1:0] cnt);
    vec_t r;
    r.st = st; r.sp = sp; r.inf = inf; r.ee = ee; r.tr = tr; r.src = src; r.pe = pe;
    r.bl = bl; r.en = en; r.sel = sel; r.busy = busy; r.done = done; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic en, sel, busy, done,
                         input logic [CW-1:0] cnt);
    chk({name, " Mux_EN"}, 32'(Mux_EN), 32'(en));
    chk({name, " Mux_Sel"}, 32'(Mux_Sel), 32'(sel));
    chk({name, " Busy"}, 32'(Busy), 32'(busy));
    chk({name, " Done"}, 32'(Done), 32'(done));
    chk({name, " Period_Cnt"}, 32'(Period_Cnt), 32'(cnt));
  endtask

  // One rising edge, then sample 1 time unit later.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic clear_inputs();
    Start = 0; Stop = 0; Infinite = 0; Ext_Trig_En = 0; Retrigger = 0;
    Src_Sel = 0; Burst_Len = '0; Holdoff_Len = '0; Period_End = 0;
  endtask

  initial begin
    //           st sp in ee tr sr pe  bl    en se bu dn cnt
    // Burst of 3, marker source; config changes and Start while busy are ignored.
    vecs.push_back(v(1, 0, 0, 0, 0, 1, 0, 4'd3, 1, 1, 1, 0, 4'd0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 4'd0, 1, 1, 1, 0, 4'd0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 4'd0, 1, 1, 1, 0, 4'd1));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 1, 4'd1, 1, 1, 1, 0, 4'd2));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 4'd0, 1, 1, 1, 0, 4'd2));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 4'd0, 0, 0, 0, 1, 4'd3));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 4'd3));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 4'd0, 0, 0, 0, 0, 4'd3));
    // Burst_Len=0: Done only, count cleared.
    vecs.push_back(v(1, 0, 0, 0, 0, 1, 0, 4'd0, 0, 0, 0, 1, 4'd0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 4'd0));
    // Start with Stop stays idle; Stop alone in idle is ignored.
    vecs.push_back(v(1, 1, 0, 0, 0, 1, 0, 4'd3, 0, 0, 0, 0, 4'd0));
    vecs.push_back(v(0, 1, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 4'd0));
    // Stop together with final Period_End: no Done.
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 4'd2, 1, 0, 1, 0, 4'd0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 4'd0, 1, 0, 1, 0, 4'd1));
    vecs.push_back(v(0, 1, 0, 0, 0, 0, 1, 4'd0, 0, 0, 0, 0, 4'd1));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 4'd1));
    // External trigger held high at Start: no edge until low-then-high.
    vecs.push_back(v(1, 0, 0, 1, 1, 1, 0, 4'd1, 0, 0, 1, 0, 4'd0));
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 0, 4'd0, 0, 0, 1, 0, 4'd0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 1, 0, 4'd0));
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 0, 4'd0, 1, 1, 1, 0, 4'd0));
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 1, 4'd0, 0, 0, 0, 1, 4'd1));
    // Stop in WAIT_TRIG, then an edge in idle does nothing.
    vecs.push_back(v(1, 0, 0, 1, 0, 0, 0, 4'd1, 0, 0, 1, 0, 4'd0));
    vecs.push_back(v(0, 1, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 4'd0));
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 0, 4'd0, 0, 0, 0, 0, 4'd0));

    // Reset state.
    clear_inputs();
    Ext_Trig = 0;
    step();
    step();
    chk_all("reset", 0, 0, 0, 0, 4'd0);
    Reset = 0;
    step();
    chk_all("post_reset", 0, 0, 0, 0, 4'd0);

    foreach (vecs[i]) begin
      Start = vecs[i].st; Stop = vecs[i].sp; Infinite = vecs[i].inf;
      Ext_Trig_En = vecs[i].ee; Retrigger = 1'b0; Ext_Trig = vecs[i].tr;
      Src_Sel = vecs[i].src; Period_End = vecs[i].pe; Burst_Len = vecs[i].bl;
      Holdoff_Len = '0;
      step();
      chk_all($sformatf("row%0d", i), vecs[i].en, vecs[i].sel, vecs[i].busy,
              vecs[i].done, vecs[i].cnt);
    end

    // Infinite run with Burst_Len=0: count wraps 15 -> 0, never Done.
    clear_inputs();
    Ext_Trig = 0;
    step();
    Start = 1; Infinite = 1; Src_Sel = 0;
    step();
    clear_inputs();
    chk_all("inf_start", 1, 0, 1, 0, 4'd0);
    for (int i = 1; i <= 17; i++) begin
      Period_End = 1;
      step();
      Period_End = 0;
      chk($sformatf("inf_cnt%0d", i), 32'(Period_Cnt), 32'(i % 16));
      chk($sformatf("inf_done%0d", i), 32'(Done), 32'd0);
    end
    chk("inf_en_after_wrap", 32'(Mux_EN), 32'd1);
    Stop = 1;
    step();
    Stop = 0;
    chk_all("inf_stop", 0, 0, 0, 0, 4'd1);

    // Retrigger: Burst_Len=2, Holdoff_Len=5.
    Start = 1; Ext_Trig_En = 1; Retrigger = 1; Burst_Len = 4'd2;
    Holdoff_Len = 8'd5; Src_Sel = 1;
    step();
    clear_inputs();
    chk_all("rt_arm", 0, 0, 1, 0, 4'd0);
    Ext_Trig = 1;
    step();
    chk_all("rt_trig", 1, 1, 1, 0, 4'd0);
    Period_End = 1;
    step();
    chk_all("rt_p1", 1, 1, 1, 0, 4'd1);
    step();
    Period_End = 0;
    chk_all("rt_done", 0, 0, 1, 1, 4'd2);
    Ext_Trig = 0;
    step();
    chk_all("rt_hold1", 0, 0, 1, 0, 4'd2);
    step();
    Ext_Trig = 1;
    step();
    chk_all("rt_hold3_edge_ignored", 0, 0, 1, 0, 4'd2);
    step();
    chk_all("rt_hold4", 0, 0, 1, 0, 4'd2);
    step();
    chk_all("rt_hold_end", 0, 0, 1, 0, 4'd0);
    step();
    chk_all("rt_wait_level_high", 0, 0, 1, 0, 4'd0);
    Ext_Trig = 0;
    step();
    Ext_Trig = 1;
    step();
    chk_all("rt_rerun", 1, 1, 1, 0, 4'd0);
    Stop = 1;
    step();
    Stop = 0;
    chk_all("rt_stop", 0, 0, 0, 0, 4'd0);

    // Asynchronous reset mid-run.
    Ext_Trig = 0;
    Start = 1; Infinite = 1; Src_Sel = 1;
    step();
    clear_inputs();
    Period_End = 1;
    step();
    step();
    Period_End = 0;
    chk_all("ar_running", 1, 1, 1, 0, 4'd2);
    #2;
    Reset = 1;
    #1;
    chk_all("ar_async", 0, 0, 0, 0, 4'd0);
    #1;
    Reset = 0;
    step();
    chk_all("ar_after", 0, 0, 0, 0, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
